// File: rtl/mini_dmem_responder_pkg.sv
// Shared MMIO definitions for the mini core data port: I/O page, register word offsets, CTRL layout.
// Offsets are word indices (byte offset >> 2) because the low two address bits are ignored.
package mini_dmem_responder_pkg;

    localparam logic [23:0] IO_PAGE_DEFAULT = 24'h0000FF;

    // Byte offsets 0x00, 0x04, 0x08, 0x0C, 0x10.
    localparam logic [5:0] WOFF_TIMER  = 6'h00;
    localparam logic [5:0] WOFF_CMP    = 6'h01;
    localparam logic [5:0] WOFF_CTRL   = 6'h02;
    localparam logic [5:0] WOFF_STATUS = 6'h03;
    localparam logic [5:0] WOFF_GPIO   = 6'h04;

    localparam int CTRL_TMR_EN = 0;
    localparam int CTRL_IRQ_EN = 1;

    typedef struct packed {
        logic irq_en;
        logic tmr_en;
    } ctrl_t;

endpackage

// File: rtl/mini_mmio_timer.sv
// Timer block: TIMER counter, CMP, CTRL and the sticky match flag driving a level IRQ.
// Reads are combinational on the word offset; writes and counting happen on the rising edge.
module mini_mmio_timer
    import mini_dmem_responder_pkg::*;
(
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        we_i,
    input  logic [5:0]  woff_i,
    input  logic [31:0] wdata_i,
    output logic [31:0] rdata_o,
    output logic        irq_o
);

    logic [31:0] timer_q, timer_d;
    logic [31:0] cmp_q, cmp_d;
    ctrl_t       ctrl_q, ctrl_d;
    logic        flag_q, flag_d;
    logic        match;

    always_comb begin
        timer_d = ctrl_q.tmr_en ? timer_q + 32'd1 : timer_q;
        cmp_d   = cmp_q;
        ctrl_d  = ctrl_q;
        flag_d  = flag_q;
        match   = ctrl_q.tmr_en && (timer_q == cmp_q);
        if (we_i) begin
            case (woff_i)
                WOFF_TIMER:  timer_d = wdata_i;
                WOFF_CMP:    cmp_d   = wdata_i;
                WOFF_CTRL:   ctrl_d  = '{irq_en: wdata_i[CTRL_IRQ_EN], tmr_en: wdata_i[CTRL_TMR_EN]};
                WOFF_STATUS: if (wdata_i[0]) flag_d = 1'b0;
                default:     ;
            endcase
        end
        // A match on the same edge as a W1C clear must leave the flag set.
        if (match) flag_d = 1'b1;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            timer_q <= '0;
            cmp_q   <= '0;
            ctrl_q  <= '0;
            flag_q  <= 1'b0;
        end else begin
            timer_q <= timer_d;
            cmp_q   <= cmp_d;
            ctrl_q  <= ctrl_d;
            flag_q  <= flag_d;
        end
    end

    always_comb begin
        rdata_o = '0;
        case (woff_i)
            WOFF_TIMER:  rdata_o = timer_q;
            WOFF_CMP:    rdata_o = cmp_q;
            WOFF_CTRL:   rdata_o = {30'd0, ctrl_q.irq_en, ctrl_q.tmr_en};
            WOFF_STATUS: rdata_o = {31'd0, flag_q};
            default:     rdata_o = '0;
        endcase
    end

    assign irq_o = flag_q & ctrl_q.irq_en;

endmodule

// File: rtl/mini_dmem_responder.sv
// M-stage data responder: word RAM plus one MMIO page (timer block, GPIO), zero-latency reads.
// Reads show pre-edge state, so a same-cycle load/store to one address returns the old data.
module mini_dmem_responder
    import mini_dmem_responder_pkg::*;
#(
    parameter int          RAM_WORDS = 64,
    parameter logic [23:0] IO_PAGE   = IO_PAGE_DEFAULT,
    parameter int          GPIO_W    = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              MemWriteM,
    input  logic [31:0]       ALUResultM,
    input  logic [31:0]       WriteDataM,
    output logic [31:0]       ReadDataM,
    output logic [GPIO_W-1:0] gpio_out,
    output logic              timer_irq
);

    localparam int IDX_W = $clog2(RAM_WORDS);

    logic              io_sel;
    logic [5:0]        woff;
    logic [IDX_W-1:0]  ram_idx;
    logic [31:0]       ram_q [RAM_WORDS];
    logic [GPIO_W-1:0] gpio_q, gpio_d;
    logic [31:0]       tmr_rdata;
    logic              unused_addr_bits;

    assign io_sel           = (ALUResultM[31:8] == IO_PAGE);
    assign woff             = ALUResultM[7:2];
    assign ram_idx          = ALUResultM[IDX_W+1:2];
    assign unused_addr_bits = &{1'b0, ALUResultM[1:0]};

    // RAM contents deliberately survive reset.
    always_ff @(posedge clk) begin
        if (MemWriteM && !io_sel) ram_q[ram_idx] <= WriteDataM;
    end

    always_comb begin
        gpio_d = gpio_q;
        if (MemWriteM && io_sel && (woff == WOFF_GPIO)) gpio_d = WriteDataM[GPIO_W-1:0];
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) gpio_q <= '0;
        else        gpio_q <= gpio_d;
    end

    mini_mmio_timer u_timer (
        .clk_i   (clk),
        .rst_ni  (reset),
        .we_i    (MemWriteM && io_sel),
        .woff_i  (woff),
        .wdata_i (WriteDataM),
        .rdata_o (tmr_rdata),
        .irq_o   (timer_irq)
    );

    always_comb begin
        ReadDataM = ram_q[ram_idx];
        if (io_sel) begin
            if (woff == WOFF_GPIO) ReadDataM = {{(32-GPIO_W){1'b0}}, gpio_q};
            else                   ReadDataM = tmr_rdata;
        end
    end

    assign gpio_out = gpio_q;

endmodule

// File: tb/tb_mini_dmem_responder.sv
// Bench for mini_dmem_responder: directed scenarios plus random traffic against a behavioural memory model.
module tb_mini_dmem_responder;

    logic        clk;
    logic        reset;
    logic        MemWriteM;
    logic [31:0] ALUResultM;
    logic [31:0] WriteDataM;
    logic [31:0] ReadDataM;
    logic [7:0]  gpio_out;
    logic        timer_irq;

    int checks = 0;
    int errors = 0;

    localparam logic [31:0] IO = 32'h0000FF00;

    // Reference model state
    logic [31:0] ram_m [64];
    logic [31:0] tmr_m, cmp_m;
    logic        en_m, irqen_m, flag_m;
    logic [7:0]  gpio_m;

    mini_dmem_responder dut (
        .clk        (clk),
        .reset      (reset),
        .MemWriteM  (MemWriteM),
        .ALUResultM (ALUResultM),
        .WriteDataM (WriteDataM),
        .ReadDataM  (ReadDataM),
        .gpio_out   (gpio_out),
        .timer_irq  (timer_irq)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic m_reset();
        tmr_m = 0; cmp_m = 0; en_m = 0; irqen_m = 0; flag_m = 0; gpio_m = 0;
    endtask

    function automatic logic [31:0] m_read(input logic [31:0] a);
        if (a[31:8] == 24'h0000FF) begin
            case (a[7:0] & 8'hFC)
                8'h00:   return tmr_m;
                8'h04:   return cmp_m;
                8'h08:   return {30'd0, irqen_m, en_m};
                8'h0C:   return {31'd0, flag_m};
                8'h10:   return {24'd0, gpio_m};
                default: return 32'd0;
            endcase
        end
        return ram_m[(a >> 2) % 64];
    endfunction

    task automatic m_edge(input logic we, input logic [31:0] a, input logic [31:0] d);
        logic        hit;
        logic        io;
        logic [7:0]  off;
        logic [31:0] nt;
        hit = en_m && (tmr_m == cmp_m);
        io  = (a[31:8] == 24'h0000FF);
        off = a[7:0] & 8'hFC;
        nt  = en_m ? tmr_m + 1 : tmr_m;
        if (we && !io) ram_m[(a >> 2) % 64] = d;
        if (we && io) begin
            if (off == 8'h00) nt = d;
            if (off == 8'h04) cmp_m = d;
            if (off == 8'h08) begin en_m = d[0]; irqen_m = d[1]; end
            if (off == 8'h0C && d[0]) flag_m = 0;
            if (off == 8'h10) gpio_m = d[7:0];
        end
        if (hit) flag_m = 1;
        tmr_m = nt;
    endtask

    // One bus cycle: drive, sample the combinational read before the edge, advance model at the edge.
    task automatic do_cycle(input logic we, input logic [31:0] a, input logic [31:0] d,
                            output logic [31:0] rd, output logic [31:0] exp_rd);
        MemWriteM  = we;
        ALUResultM = a;
        WriteDataM = d;
        #3;
        rd     = ReadDataM;
        exp_rd = m_read(a);
        @(posedge clk);
        m_edge(we, a, d);
        #1;
    endtask

    task automatic test_reset();
        logic [31:0] rd, ex;
        ALUResultM = IO;
        #2;
        checks++;
        if (ReadDataM !== 32'd0) begin errors++; $display("FAIL reset_timer_read: got %h expected %h", ReadDataM, 32'd0); end
        checks++;
        if (gpio_out !== 8'd0) begin errors++; $display("FAIL reset_gpio: got %h expected %h", gpio_out, 8'd0); end
        checks++;
        if (timer_irq !== 1'b0) begin errors++; $display("FAIL reset_irq: got %b expected 0", timer_irq); end
        @(posedge clk);
        #1;
        reset = 1'b1;
        m_reset();
        for (int i = 0; i < 64; i++) do_cycle(1'b1, i * 4, $urandom, rd, ex);
    endtask

    task automatic test_alias();
        logic [31:0] rd, ex;
        do_cycle(1'b1, 32'h04, 32'hDEADBEEF, rd, ex);
        do_cycle(1'b0, 32'h04, 32'h0, rd, ex);
        checks++;
        if (rd !== 32'hDEADBEEF) begin errors++; $display("FAIL alias_load_04: got %h expected %h", rd, 32'hDEADBEEF); end
        do_cycle(1'b0, 32'h104, 32'h0, rd, ex);
        checks++;
        if (rd !== 32'hDEADBEEF) begin errors++; $display("FAIL alias_load_104: got %h expected %h", rd, 32'hDEADBEEF); end
    endtask

    task automatic test_same_cycle();
        logic [31:0] rd, ex;
        do_cycle(1'b1, 32'h08, 32'h0, rd, ex);
        do_cycle(1'b1, 32'h08, 32'h1, rd, ex);
        checks++;
        if (rd !== 32'h0) begin errors++; $display("FAIL same_cycle_old: got %h expected %h", rd, 32'h0); end
        do_cycle(1'b0, 32'h08, 32'h0, rd, ex);
        checks++;
        if (rd !== 32'h1) begin errors++; $display("FAIL same_cycle_new: got %h expected %h", rd, 32'h1); end
    endtask

    task automatic test_timer_match();
        logic [31:0] rd, ex;
        do_cycle(1'b1, IO | 32'h04, 32'd5, rd, ex);
        do_cycle(1'b1, IO | 32'h08, 32'h3, rd, ex);
        do_cycle(1'b1, IO | 32'h00, 32'd0, rd, ex);
        for (int i = 0; i < 5; i++) begin
            do_cycle(1'b0, IO | 32'h00, 32'd0, rd, ex);
            checks++;
            if (rd !== i) begin errors++; $display("FAIL timer_count_%0d: got %h expected %h", i, rd, i); end
        end
        checks++;
        if (timer_irq !== 1'b0) begin errors++; $display("FAIL timer_irq_early: got %b expected 0", timer_irq); end
        do_cycle(1'b0, IO | 32'h00, 32'd0, rd, ex);
        checks++;
        if (rd !== 32'd5) begin errors++; $display("FAIL timer_reads_5: got %h expected %h", rd, 32'd5); end
        do_cycle(1'b0, IO | 32'h0C, 32'd0, rd, ex);
        checks++;
        if (rd !== 32'd1) begin errors++; $display("FAIL match_flag_set: got %h expected %h", rd, 32'd1); end
        checks++;
        if (timer_irq !== 1'b1) begin errors++; $display("FAIL timer_irq_set: got %b expected 1", timer_irq); end
    endtask

    task automatic test_wrap();
        logic [31:0] rd, ex;
        do_cycle(1'b1, IO | 32'h0C, 32'd1, rd, ex);
        do_cycle(1'b1, IO | 32'h04, 32'd3, rd, ex);
        do_cycle(1'b1, IO | 32'h00, 32'hFFFFFFFE, rd, ex);
        do_cycle(1'b0, IO | 32'h00, 32'd0, rd, ex);
        checks++;
        if (rd !== 32'hFFFFFFFE) begin errors++; $display("FAIL wrap_load: got %h expected %h", rd, 32'hFFFFFFFE); end
        do_cycle(1'b0, IO | 32'h00, 32'd0, rd, ex);
        checks++;
        if (rd !== 32'hFFFFFFFF) begin errors++; $display("FAIL wrap_max: got %h expected %h", rd, 32'hFFFFFFFF); end
        do_cycle(1'b0, IO | 32'h00, 32'd0, rd, ex);
        checks++;
        if (rd !== 32'h0) begin errors++; $display("FAIL wrap_zero: got %h expected %h", rd, 32'h0); end
        do_cycle(1'b0, IO | 32'h0C, 32'd0, rd, ex);
        checks++;
        if (rd !== 32'h0) begin errors++; $display("FAIL wrap_no_match: got %h expected %h", rd, 32'h0); end
    endtask

    task automatic test_w1c();
        logic [31:0] rd, ex;
        do_cycle(1'b1, IO | 32'h08, 32'h2, rd, ex);
        do_cycle(1'b1, IO | 32'h0C, 32'h1, rd, ex);
        do_cycle(1'b1, IO | 32'h04, 32'd20, rd, ex);
        do_cycle(1'b1, IO | 32'h00, 32'd18, rd, ex);
        do_cycle(1'b1, IO | 32'h08, 32'h3, rd, ex);
        do_cycle(1'b0, IO | 32'h00, 32'd0, rd, ex);
        do_cycle(1'b0, IO | 32'h00, 32'd0, rd, ex);
        checks++;
        if (rd !== 32'd19) begin errors++; $display("FAIL w1c_pre_count: got %h expected %h", rd, 32'd19); end
        do_cycle(1'b1, IO | 32'h0C, 32'h1, rd, ex);
        do_cycle(1'b0, IO | 32'h0C, 32'd0, rd, ex);
        checks++;
        if (rd !== 32'd1) begin errors++; $display("FAIL w1c_set_wins: got %h expected %h", rd, 32'd1); end
        do_cycle(1'b1, IO | 32'h0C, 32'h0, rd, ex);
        do_cycle(1'b0, IO | 32'h0C, 32'd0, rd, ex);
        checks++;
        if (rd !== 32'd1) begin errors++; $display("FAIL w1c_zero_noop: got %h expected %h", rd, 32'd1); end
        do_cycle(1'b1, IO | 32'h0C, 32'h1, rd, ex);
        do_cycle(1'b0, IO | 32'h0C, 32'd0, rd, ex);
        checks++;
        if (rd !== 32'd0) begin errors++; $display("FAIL w1c_clear: got %h expected %h", rd, 32'd0); end
        checks++;
        if (timer_irq !== 1'b0) begin errors++; $display("FAIL w1c_irq_drop: got %b expected 0", timer_irq); end
    endtask

    task automatic test_random();
        logic [31:0] rd, ex, a, d;
        logic        we;
        for (int n = 0; n < 400; n++) begin
            we = 1'(($urandom_range(0, 1)));
            d  = $urandom;
            if ($urandom_range(0, 3) == 0) begin
                a = $urandom;
                if (a[31:8] == 24'h0000FF) a = a ^ 32'h8000_0000;
                if (((a >> 2) % 64) == 1) we = 1'b0;
            end else begin
                a = IO | (32'($urandom_range(0, 7)) << 2) | 32'($urandom_range(0, 3));
                if ((a[7:0] & 8'hFC) <= 8'h04) d = 32'($urandom_range(0, 40));
                if ((a[7:0] & 8'hFC) == 8'h08) d = d | 32'h1;
            end
            do_cycle(we, a, d, rd, ex);
            checks++;
            if (rd !== ex) begin errors++; $display("FAIL rand_read[%0d] @%h: got %h expected %h", n, a, rd, ex); end
            checks++;
            if (timer_irq !== (flag_m & irqen_m)) begin errors++; $display("FAIL rand_irq[%0d]: got %b expected %b", n, timer_irq, flag_m & irqen_m); end
            checks++;
            if (gpio_out !== gpio_m) begin errors++; $display("FAIL rand_gpio[%0d]: got %h expected %h", n, gpio_out, gpio_m); end
        end
    endtask

    task automatic test_async_reset();
        logic [31:0] rd, ex;
        do_cycle(1'b1, IO | 32'h10, 32'hA5, rd, ex);
        do_cycle(1'b1, IO | 32'h08, 32'h1, rd, ex);
        do_cycle(1'b1, IO | 32'h00, 32'd100, rd, ex);
        MemWriteM  = 1'b0;
        ALUResultM = IO;
        #1;
        checks++;
        if (gpio_out !== 8'hA5) begin errors++; $display("FAIL arst_gpio_before: got %h expected %h", gpio_out, 8'hA5); end
        reset = 1'b0;
        #1;
        checks++;
        if (gpio_out !== 8'h00) begin errors++; $display("FAIL arst_gpio: got %h expected %h", gpio_out, 8'h00); end
        checks++;
        if (ReadDataM !== 32'd0) begin errors++; $display("FAIL arst_timer: got %h expected %h", ReadDataM, 32'd0); end
        checks++;
        if (timer_irq !== 1'b0) begin errors++; $display("FAIL arst_irq: got %b expected 0", timer_irq); end
        #1;
        reset = 1'b1;
        m_reset();
        @(posedge clk);
        #1;
        do_cycle(1'b0, 32'h104, 32'd0, rd, ex);
        checks++;
        if (rd !== 32'hDEADBEEF) begin errors++; $display("FAIL arst_ram_kept: got %h expected %h", rd, 32'hDEADBEEF); end
        do_cycle(1'b0, IO | 32'h00, 32'd0, rd, ex);
        checks++;
        if (rd !== 32'd0) begin errors++; $display("FAIL arst_timer_stopped: got %h expected %h", rd, 32'd0); end
    endtask

    initial begin
        reset      = 1'b0;
        MemWriteM  = 1'b0;
        ALUResultM = '0;
        WriteDataM = '0;
        test_reset();
        test_alias();
        test_same_cycle();
        test_timer_match();
        test_wrap();
        test_w1c();
        test_random();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
